stage_1: RTL and testbench

Instruction-fetch stage of the five-stage RISC-V pipeline, directly upstream of the decode stage (`stage_2`). Owns the fetch PC and issues single-outstanding word reads to instruction memory. Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake. Applies branch redirects (`b_taken`/`b_pc`) coming back from decode by flushing the FIFO and discarding any in-flight read.

---
 rtl/stage_1_pkg.sv | 19 +
 rtl/stage_1_if.sv | 29 ++
 rtl/stage_1_fetch_fifo.sv | 45 ++++
 rtl/stage_1.sv | 98 +++++++++
 tb/tb_stage_1.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/stage_1_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch top, its FIFO and the stage interface.
package stage_1_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_DROP = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] counter;
   } fetch_entry_t;

endpackage

// File: rtl/stage_1_if.sv
// Fetch stage bus: instruction-memory read port plus decode handshake.
// master is the fetch side, slave is memory/decode.
interface stage_1_if;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_ack;
   logic [31:0] i_mem_data;
   logic        i_b_taken;
   logic [31:0] i_b_pc;
   logic        i_ready;
   logic        valid;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] counter;

   modport master (
      output o_mem_req, o_mem_addr,
      input  i_mem_ack, i_mem_data,
      input  i_b_taken, i_b_pc, i_ready,
      output valid, inst, pc, counter
   );

   modport slave (
      input  o_mem_req, o_mem_addr,
      output i_mem_ack, i_mem_data,
      output i_b_taken, i_b_pc, i_ready,
      input  valid, inst, pc, counter
   );
endinterface

// File: rtl/stage_1_fetch_fifo.sv
// Small power-of-two FIFO holding fetched {inst, pc, counter} entries.
// Flush empties it and wins over any same-cycle push or pop.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 32,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   input  logic          flush,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign head = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: rtl/stage_1.sv
// Instruction-fetch stage: fetch PC, single-outstanding read FSM,
// sequence counter and redirect handling in front of a small FIFO.
module stage_1
   import stage_1_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input logic       i_clk,
   input logic       i_rst,
   stage_1_if.master bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state;
   logic [31:0]   pc_r;
   logic [31:0]   rd_pc;
   logic [31:0]   seq;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          room;
   logic          issue;
   logic          head_valid;
   fetch_entry_t  wr_entry;
   fetch_entry_t  head;

   assign push = (state == FETCH_WAIT) && bus.i_mem_ack
                 && !bus.i_b_taken;

   // Pops are not credited here, so a full FIFO never sees push+pop.
   assign room = (count + CW'(push)) < CW'(DEPTH);

   assign issue = i_rst && !bus.i_b_taken && room
                  && ((state == FETCH_IDLE)
                      || ((state == FETCH_WAIT) && bus.i_mem_ack));

   assign head_valid = (count != '0);
   assign pop        = head_valid && bus.i_ready && !bus.i_b_taken;

   assign wr_entry = '{
      inst:    bus.i_mem_data,
      pc:      rd_pc,
      counter: seq
   };

   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .flush (bus.i_b_taken),
      .head  (head),
      .count (count)
   );

   assign bus.o_mem_req  = issue;
   assign bus.o_mem_addr = pc_r;
   assign bus.valid      = head_valid;
   assign bus.inst       = head.inst;
   assign bus.pc         = head.pc;
   assign bus.counter    = head.counter;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state <= FETCH_IDLE;
         pc_r  <= RESET_PC;
         rd_pc <= RESET_PC;
         seq   <= '0;
      end else begin
         if (push) seq <= seq + 32'd1;
         if (issue) begin
            pc_r  <= pc_r + 32'd4;
            rd_pc <= pc_r;
         end
         if (bus.i_b_taken) pc_r <= bus.i_b_pc & ~32'h3;
         unique case (state)
            FETCH_IDLE:
               state <= issue ? FETCH_WAIT : FETCH_IDLE;
            FETCH_WAIT:
               if (bus.i_b_taken)
                  state <= bus.i_mem_ack ? FETCH_IDLE : FETCH_DROP;
               else if (bus.i_mem_ack)
                  state <= issue ? FETCH_WAIT : FETCH_IDLE;
            FETCH_DROP:
               if (bus.i_mem_ack) state <= FETCH_IDLE;
            default:
               state <= FETCH_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_1.sv
// Directed per-cycle vector bench for the fetch stage.
// Memory responses are scripted in the table, one row per clock.
module tb_stage_1;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   stage_1_if bus ();

   stage_1 #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ack;
      logic [31:0] data;
      logic        bt;
      logic [31:0] bpc;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        val;
      logic [31:0] pc;
      logic [31:0] cnt;
   } vec_t;

   localparam int NV = 31;
   vec_t tbl [NV];

   function automatic vec_t mk(
      input logic        ack,
      input logic [31:0] data,
      input logic        bt,
      input logic [31:0] bpc,
      input logic        rdy,
      input logic        req,
      input logic [31:0] addr,
      input logic        val,
      input logic [31:0] pc,
      input logic [31:0] cnt
   );
      vec_t v;
      v.ack  = ack;
      v.data = data;
      v.bt   = bt;
      v.bpc  = bpc;
      v.rdy  = rdy;
      v.req  = req;
      v.addr = addr;
      v.val  = val;
      v.pc   = pc;
      v.cnt  = cnt;
      return v;
   endfunction

   task automatic chk(
      input string       nm,
      input int          idx,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.i_mem_ack  = 1'b0;
      bus.i_mem_data = 32'h0;
      bus.i_b_taken  = 1'b0;
      bus.i_b_pc     = 32'h0;
      bus.i_ready    = 1'b1;
   endtask

   task automatic chk_zero(input int tag);
      chk("rst_valid", tag, 32'(bus.valid), 32'h0);
      chk("rst_inst", tag, bus.inst, 32'h0);
      chk("rst_pc", tag, bus.pc, 32'h0);
      chk("rst_counter", tag, bus.counter, 32'h0);
      chk("rst_req", tag, 32'(bus.o_mem_req), 32'h0);
      chk("rst_addr", tag, bus.o_mem_addr, 32'h0);
   endtask

   task automatic run(input int i);
      bus.i_mem_ack  = tbl[i].ack;
      bus.i_mem_data = tbl[i].data;
      bus.i_b_taken  = tbl[i].bt;
      bus.i_b_pc     = tbl[i].bpc;
      bus.i_ready    = tbl[i].rdy;
      #1;
      chk("req", i, 32'(bus.o_mem_req), 32'(tbl[i].req));
      chk("addr", i, bus.o_mem_addr, tbl[i].addr);
      chk("valid", i, 32'(bus.valid), 32'(tbl[i].val));
      if (tbl[i].val) begin
         chk("inst", i, bus.inst, tbl[i].pc + 32'h100);
         chk("pc", i, bus.pc, tbl[i].pc);
         chk("counter", i, bus.counter, tbl[i].cnt);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // ack data bt bpc rdy | req addr valid pc counter
      // stream from reset, 1-cycle memory
      tbl[0]  = mk(0, 32'h0,   0, 0, 1, 1, 32'h00, 0, 0,     0);
      tbl[1]  = mk(1, 32'h100, 0, 0, 1, 1, 32'h04, 0, 0,     0);
      tbl[2]  = mk(1, 32'h104, 0, 0, 1, 0, 32'h08, 1, 32'h0, 0);
      tbl[3]  = mk(0, 32'h0,   0, 0, 1, 1, 32'h08, 1, 32'h4, 1);
      tbl[4]  = mk(1, 32'h108, 0, 0, 1, 1, 32'h0C, 0, 0,     0);
      // backpressure: fill both entries, hold six cycles
      tbl[5]  = mk(1, 32'h10C, 0, 0, 0, 0, 32'h10, 1, 32'h8, 2);
      tbl[6]  = mk(0, 32'h0,   0, 0, 0, 0, 32'h10, 1, 32'h8, 2);
      tbl[7]  = mk(0, 32'h0,   0, 0, 0, 0, 32'h10, 1, 32'h8, 2);
      tbl[8]  = mk(0, 32'h0,   0, 0, 0, 0, 32'h10, 1, 32'h8, 2);
      tbl[9]  = mk(0, 32'h0,   0, 0, 0, 0, 32'h10, 1, 32'h8, 2);
      tbl[10] = mk(0, 32'h0,   0, 0, 0, 0, 32'h10, 1, 32'h8, 2);
      tbl[11] = mk(0, 32'h0,   0, 0, 1, 0, 32'h10, 1, 32'h8, 2);
      tbl[12] = mk(0, 32'h0,   0, 0, 1, 1, 32'h10, 1, 32'hC, 3);
      tbl[13] = mk(1, 32'h110, 0, 0, 1, 1, 32'h14, 0, 0,     0);
      tbl[14] = mk(1, 32'h114, 0, 0, 1, 0, 32'h18, 1, 32'h10, 4);
      tbl[15] = mk(0, 32'h0,   0, 0, 1, 1, 32'h18, 1, 32'h14, 5);
      // redirect while waiting, 3-cycle memory
      tbl[16] = mk(0, 32'h0,   1, 32'h40, 1, 0, 32'h1C, 0, 0, 0);
      tbl[17] = mk(0, 32'h0,   0, 0, 1, 0, 32'h40, 0, 0, 0);
      tbl[18] = mk(1, 32'h118, 0, 0, 1, 0, 32'h40, 0, 0, 0);
      tbl[19] = mk(0, 32'h0,   0, 0, 1, 1, 32'h40, 0, 0, 0);
      tbl[20] = mk(0, 32'h0,   0, 0, 1, 0, 32'h44, 0, 0, 0);
      tbl[21] = mk(0, 32'h0,   0, 0, 1, 0, 32'h44, 0, 0, 0);
      tbl[22] = mk(1, 32'h140, 0, 0, 1, 1, 32'h44, 0, 0, 0);
      // redirect coincident with ack, FIFO non-empty
      tbl[23] = mk(1, 32'h144, 1, 32'h40, 0, 0, 32'h48, 1, 32'h40, 6);
      tbl[24] = mk(0, 32'h0,   0, 0, 1, 1, 32'h40, 0, 0, 0);
      tbl[25] = mk(1, 32'h140, 0, 0, 1, 1, 32'h44, 0, 0, 0);
      tbl[26] = mk(0, 32'h0,   0, 0, 1, 0, 32'h48, 1, 32'h40, 7);
      // misaligned target
      tbl[27] = mk(0, 32'h0,   1, 32'h43, 1, 0, 32'h48, 0, 0, 0);
      tbl[28] = mk(1, 32'h144, 0, 0, 1, 0, 32'h40, 0, 0, 0);
      tbl[29] = mk(0, 32'h0,   0, 0, 1, 1, 32'h40, 0, 0, 0);
      tbl[30] = mk(0, 32'h0,   0, 0, 1, 0, 32'h44, 0, 0, 0);

      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      #1;
      chk_zero(0);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst_n = 1'b1;
         run(i);
      end

      // reset while a read is outstanding (state WAIT after row 30)
      @(negedge clk);
      drive_idle();
      rst_n = 1'b0;
      #1;
      chk_zero(1);
      @(negedge clk);
      #1;
      chk_zero(2);

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rst_n = 1'b1;
         run(i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
